weight_mem_ctrl: RTL and testbench

Sequencer for one neuron's `Weight_Memory` instance in the CNN accelerator. It loads weights from a valid/ready stream into the memory write port at consecutive addresses. On `start` it sweeps the read port across all weights, one per cycle, honouring a `hold` back-pressure input. It flags each returned word with `w_valid`/`w_last` so the MAC stage can consume `wout` directly.

---
 rtl/cnn_pkg.sv | 14 +
 rtl/weight_addr_counter.sv | 45 ++++
 rtl/weight_mem_ctrl.sv | 132 +++++++++++++
 tb/tb_weight_mem_ctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN accelerator neuron datapath.
//   wm_state_t  : weight memory controller FSM encoding (2 bits)
//   PRETRAINED  : global switch, 1 when weight memories are ROM-initialised
package cnn_pkg;

  typedef enum logic [1:0] {
    S_LOAD = 2'd0,
    S_IDLE = 2'd1,
    S_READ = 2'd2
  } wm_state_t;

  localparam bit PRETRAINED = 1'b0;

endpackage

// File: rtl/weight_addr_counter.sv
// Clear/enable address counter with terminal-count flag.
//   clk, rst : clock, asynchronous active-high reset
//   clr_i    : synchronous clear (wins over en_i)
//   en_i     : advance; at the terminal value the counter returns to 0
//   cnt_o    : current count
//   tc_o     : cnt_o equals TERM
module weight_addr_counter #(
  parameter int WIDTH = 10,
  parameter int TERM  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] cnt_o,
  output logic             tc_o
);

  localparam logic [WIDTH-1:0] TERM_VAL = WIDTH'(TERM);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  assign tc_o  = (cnt_q == TERM_VAL);
  assign cnt_o = cnt_q;

  // Advancing past the terminal value folds back to 0, so the count never
  // leaves 0..TERM.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = tc_o ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/weight_mem_ctrl.sv
// Sequencer for one neuron's Weight_Memory: loads a weight set from a
// valid/ready stream, then sweeps the read port on start, flagging each
// returned word for the MAC stage.
//   clk, rst                  : clock, asynchronous active-high reset
//   wt_valid/wt_data/wt_ready : weight load stream
//   mem_wen/mem_wadd/mem_win  : memory write port
//   start, reload, hold       : sweep request, reload request, read stall
//   mem_ren/mem_radd          : memory read port
//   w_valid, w_last           : wout is fresh / is the final weight
//   loaded, busy              : weight set present / sweep in flight
//
// state  | meaning
// S_LOAD | accepting weights into consecutive addresses
// S_IDLE | weight set present, waiting for start or reload
// S_READ | issuing one read per non-held cycle
module weight_mem_ctrl #(
  parameter int NUM_WEIGHT = 3,
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 16,
  parameter bit PRETRAINED = cnn_pkg::PRETRAINED
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wt_valid,
  input  logic [DATA_WIDTH-1:0] wt_data,
  output logic                  wt_ready,
  output logic                  mem_wen,
  output logic [ADDR_WIDTH-1:0] mem_wadd,
  output logic [DATA_WIDTH-1:0] mem_win,
  input  logic                  start,
  input  logic                  reload,
  input  logic                  hold,
  output logic                  mem_ren,
  output logic [ADDR_WIDTH-1:0] mem_radd,
  output logic                  w_valid,
  output logic                  w_last,
  output logic                  loaded,
  output logic                  busy
);
  import cnn_pkg::*;

  localparam wm_state_t RESET_STATE = PRETRAINED ? S_IDLE : S_LOAD;

  wm_state_t state_q, state_d;
  logic loaded_q, loaded_d;
  logic w_valid_q, w_last_q;

  logic [ADDR_WIDTH-1:0] wcnt, rcnt;
  logic wcnt_tc, rcnt_tc;
  logic wcnt_clr, rcnt_clr;

  weight_addr_counter #(.WIDTH(ADDR_WIDTH), .TERM(NUM_WEIGHT-1)) u_wcnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (wcnt_clr),
    .en_i  (mem_wen),
    .cnt_o (wcnt),
    .tc_o  (wcnt_tc)
  );

  weight_addr_counter #(.WIDTH(ADDR_WIDTH), .TERM(NUM_WEIGHT-1)) u_rcnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (rcnt_clr),
    .en_i  (mem_ren),
    .cnt_o (rcnt),
    .tc_o  (rcnt_tc)
  );

  always_comb begin
    state_d  = state_q;
    loaded_d = loaded_q;
    wt_ready = 1'b0;
    mem_wen  = 1'b0;
    mem_ren  = 1'b0;
    wcnt_clr = 1'b0;
    rcnt_clr = 1'b0;
    case (state_q)
      S_LOAD: begin
        wt_ready = 1'b1;
        mem_wen  = wt_valid;
        // The counter folds to 0 on its own at the terminal handshake.
        if (wt_valid && wcnt_tc) begin
          loaded_d = 1'b1;
          state_d  = S_IDLE;
        end
      end
      S_IDLE: begin
        // start has priority over reload
        if (start) begin
          rcnt_clr = 1'b1;
          state_d  = S_READ;
        end else if (reload) begin
          loaded_d = 1'b0;
          wcnt_clr = 1'b1;
          state_d  = S_LOAD;
        end
      end
      S_READ: begin
        mem_ren = !hold;
        if (!hold && rcnt_tc) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = RESET_STATE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= RESET_STATE;
      loaded_q  <= PRETRAINED;
      w_valid_q <= 1'b0;
      w_last_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      loaded_q  <= loaded_d;
      w_valid_q <= mem_ren;
      w_last_q  <= mem_ren && rcnt_tc;
    end
  end

  assign mem_wadd = wcnt;
  assign mem_win  = wt_data;
  assign mem_radd = rcnt;
  assign w_valid  = w_valid_q;
  assign w_last   = w_last_q;
  assign loaded   = loaded_q;
  // Stays high until the final word has been presented on wout.
  assign busy     = (state_q == S_READ) || w_valid_q;

endmodule

// File: tb/tb_weight_mem_ctrl.sv
module tb_weight_mem_ctrl;

  localparam int NW    = 4;
  localparam int NW_PT = 1;
  localparam int AW    = 10;
  localparam int DW    = 16;

  logic clk = 1'b0;
  logic rst;
  logic wt_valid, start, reload, hold;
  logic [DW-1:0] wt_data;

  logic wt_ready, mem_wen, mem_ren, w_valid, w_last, loaded, busy;
  logic [AW-1:0] mem_wadd, mem_radd;
  logic [DW-1:0] mem_win;

  logic p_wt_ready, p_mem_wen, p_mem_ren, p_w_valid, p_w_last, p_loaded, p_busy;
  logic [AW-1:0] p_mem_wadd, p_mem_radd;
  logic [DW-1:0] p_mem_win;

  always #5 clk = ~clk;

  weight_mem_ctrl #(.NUM_WEIGHT(NW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PRETRAINED(1'b0)) dut (
    .clk(clk), .rst(rst), .wt_valid(wt_valid), .wt_data(wt_data), .wt_ready(wt_ready),
    .mem_wen(mem_wen), .mem_wadd(mem_wadd), .mem_win(mem_win),
    .start(start), .reload(reload), .hold(hold),
    .mem_ren(mem_ren), .mem_radd(mem_radd), .w_valid(w_valid), .w_last(w_last),
    .loaded(loaded), .busy(busy)
  );

  weight_mem_ctrl #(.NUM_WEIGHT(NW_PT), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PRETRAINED(1'b1)) dut_pt (
    .clk(clk), .rst(rst), .wt_valid(wt_valid), .wt_data(wt_data), .wt_ready(p_wt_ready),
    .mem_wen(p_mem_wen), .mem_wadd(p_mem_wadd), .mem_win(p_mem_win),
    .start(start), .reload(reload), .hold(hold),
    .mem_ren(p_mem_ren), .mem_radd(p_mem_radd), .w_valid(p_w_valid), .w_last(p_w_last),
    .loaded(p_loaded), .busy(p_busy)
  );

  // Observed outputs of whichever instance is under test.
  logic sel;
  logic o_ready, o_wen, o_ren, o_wv, o_wl, o_loaded, o_busy;
  logic [AW-1:0] o_wadd, o_radd;
  logic [DW-1:0] o_win;
  assign o_ready  = sel ? p_wt_ready : wt_ready;
  assign o_wen    = sel ? p_mem_wen  : mem_wen;
  assign o_ren    = sel ? p_mem_ren  : mem_ren;
  assign o_wv     = sel ? p_w_valid  : w_valid;
  assign o_wl     = sel ? p_w_last   : w_last;
  assign o_loaded = sel ? p_loaded   : loaded;
  assign o_busy   = sel ? p_busy     : busy;
  assign o_wadd   = sel ? p_mem_wadd : mem_wadd;
  assign o_radd   = sel ? p_mem_radd : mem_radd;
  assign o_win    = sel ? p_mem_win  : mem_win;

  int tests_run = 0;
  int tests_failed = 0;

  // Scoreboards: expected write {addr,data} and expected read addresses.
  logic [AW+DW-1:0] wr_q[$];
  logic [AW-1:0]    rd_q[$];

  // Reference model state: 0 = load, 1 = idle, 2 = read.
  int   m_st, m_rcnt, m_wcnt;
  logic m_loaded, m_wv, m_wl;

  task automatic model_reset(input int st, input logic ld);
    m_st = st; m_loaded = ld; m_rcnt = 0; m_wcnt = 0; m_wv = 1'b0; m_wl = 1'b0;
    wr_q.delete(); rd_q.delete();
  endtask

  // Drives ncyc cycles from bit masks (bit k = cycle k) and checks every
  // output against the model in each cycle.
  task automatic run_phase(input int nw, input int ncyc, input logic [31:0] valid_m,
                           input logic [31:0] start_m, input logic [31:0] hold_m,
                           input logic [31:0] reload_m, input logic [DW-1:0] base);
    logic exp_ren, exp_hs, exp_busy, exp_ready;
    logic [AW+DW-1:0] ew;
    logic [AW-1:0] er;
    for (int k = 0; k < ncyc; k++) begin
      wt_valid = valid_m[k];
      wt_data  = DW'(base * (m_wcnt + 1));
      start    = start_m[k];
      hold     = hold_m[k];
      reload   = reload_m[k];
      exp_ren   = (m_st == 2) && !hold_m[k];
      exp_hs    = (m_st == 0) && valid_m[k];
      exp_busy  = (m_st == 2) || m_wv;
      exp_ready = (m_st == 0);
      if (exp_hs) wr_q.push_back({AW'(m_wcnt), DW'(base * (m_wcnt + 1))});
      @(negedge clk);
      tests_run++;
      if (o_ready !== exp_ready) begin tests_failed++; $display("FAIL wt_ready cyc %0d: got %b expected %b", k, o_ready, exp_ready); end
      tests_run++;
      if (o_wen !== exp_hs) begin tests_failed++; $display("FAIL mem_wen cyc %0d: got %b expected %b", k, o_wen, exp_hs); end
      if (exp_hs && o_wen === 1'b1) begin
        tests_run++;
        ew = wr_q.pop_front();
        if ({o_wadd, o_win} !== ew) begin tests_failed++; $display("FAIL write cyc %0d: got addr %0d data %h expected addr %0d data %h", k, o_wadd, o_win, ew[AW+DW-1:DW], ew[DW-1:0]); end
      end
      tests_run++;
      if (o_ren !== exp_ren) begin tests_failed++; $display("FAIL mem_ren cyc %0d: got %b expected %b", k, o_ren, exp_ren); end
      if (exp_ren && o_ren === 1'b1) begin
        tests_run++;
        if (rd_q.size() == 0) begin
          tests_failed++; $display("FAIL mem_radd cyc %0d: got %0d expected none", k, o_radd);
        end else begin
          er = rd_q.pop_front();
          if (o_radd !== er) begin tests_failed++; $display("FAIL mem_radd cyc %0d: got %0d expected %0d", k, o_radd, er); end
        end
      end
      tests_run++;
      if (o_wv !== m_wv) begin tests_failed++; $display("FAIL w_valid cyc %0d: got %b expected %b", k, o_wv, m_wv); end
      tests_run++;
      if (o_wl !== m_wl) begin tests_failed++; $display("FAIL w_last cyc %0d: got %b expected %b", k, o_wl, m_wl); end
      tests_run++;
      if (o_busy !== exp_busy) begin tests_failed++; $display("FAIL busy cyc %0d: got %b expected %b", k, o_busy, exp_busy); end
      tests_run++;
      if (o_loaded !== m_loaded) begin tests_failed++; $display("FAIL loaded cyc %0d: got %b expected %b", k, o_loaded, m_loaded); end
      // model clock edge
      m_wl = exp_ren && (m_rcnt == nw - 1);
      m_wv = exp_ren;
      case (m_st)
        0: if (exp_hs) begin
             if (m_wcnt == nw - 1) begin m_loaded = 1'b1; m_st = 1; m_wcnt = 0; end
             else m_wcnt++;
           end
        1: if (start_m[k]) begin
             m_st = 2; m_rcnt = 0;
             for (int i = 0; i < nw; i++) rd_q.push_back(AW'(i));
           end else if (reload_m[k]) begin
             m_st = 0; m_loaded = 1'b0; m_wcnt = 0;
           end
        default: if (exp_ren) begin
             if (m_rcnt == nw - 1) begin m_st = 1; m_rcnt = 0; end
             else m_rcnt++;
           end
      endcase
      @(posedge clk); #1;
    end
    wt_valid = 1'b0; start = 1'b0; hold = 1'b0; reload = 1'b0;
  endtask

  task automatic test_reset();
    sel = 1'b0;
    rst = 1'b1; wt_valid = 1'b0; wt_data = '0; start = 1'b0; reload = 1'b0; hold = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if ({wt_ready, loaded, busy, w_valid, w_last, mem_ren, mem_wen} !== 7'b1000000) begin
      tests_failed++; $display("FAIL reset_main: got %b expected %b", {wt_ready, loaded, busy, w_valid, w_last, mem_ren, mem_wen}, 7'b1000000);
    end
    tests_run++;
    if ({p_wt_ready, p_loaded, p_busy, p_w_valid, p_w_last, p_mem_ren} !== 6'b010000) begin
      tests_failed++; $display("FAIL reset_pretrained: got %b expected %b", {p_wt_ready, p_loaded, p_busy, p_w_valid, p_w_last, p_mem_ren}, 6'b010000);
    end
    rst = 1'b0;
    model_reset(0, 1'b0);
  endtask

  // Gapped stream of 0x0011..0x0044 with start pulses during the load.
  task automatic test_load();
    run_phase(NW, 10, 32'h65, 32'h0A, 32'h0, 32'h0, 16'h0011);
  endtask

  task automatic test_sweep();
    run_phase(NW, 8, 32'h0, 32'h1, 32'h0, 32'h0, 16'h0);
  endtask

  task automatic test_hold();
    run_phase(NW, 9, 32'h0, 32'h1, 32'h0C, 32'h0, 16'h0);
  endtask

  task automatic test_conflicts();
    // start/reload while reading are ignored
    run_phase(NW, 8, 32'h0, 32'h1D, 32'h0, 32'h0C, 16'h0);
    // start and reload together: sweep wins, loaded stays 1
    run_phase(NW, 7, 32'h0, 32'h1, 32'h0, 32'h1, 16'h0);
    // reload alone, then refill back-to-back
    run_phase(NW, 3, 32'h0, 32'h0, 32'h0, 32'h1, 16'h0);
    run_phase(NW, 6, 32'hF, 32'h0, 32'h0, 32'h0, 16'h0101);
  endtask

  task automatic test_back_to_back();
    run_phase(NW, 13, 32'h0, 32'h21, 32'h0, 32'h0, 16'h0);
  endtask

  task automatic test_reset_mid_sweep();
    run_phase(NW, 2, 32'h0, 32'h1, 32'h0, 32'h0, 16'h0);
    tests_run++;
    if ({mem_ren, w_valid} !== 2'b11) begin tests_failed++; $display("FAIL mid_sweep_active: got %b expected %b", {mem_ren, w_valid}, 2'b11); end
    #1 rst = 1'b1;
    #1;
    tests_run++;
    if ({mem_ren, w_valid, w_last, busy, loaded, wt_ready} !== 6'b000001) begin
      tests_failed++; $display("FAIL async_reset: got %b expected %b", {mem_ren, w_valid, w_last, busy, loaded, wt_ready}, 6'b000001);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset(0, 1'b0);
    run_phase(NW, 6, 32'hF, 32'h0, 32'h0, 32'h0, 16'h0A0A);
  endtask

  task automatic test_pretrained();
    rst = 1'b1;
    @(posedge clk); #1;
    tests_run++;
    if ({p_loaded, p_wt_ready} !== 2'b10) begin tests_failed++; $display("FAIL pretrained_reset: got %b expected %b", {p_loaded, p_wt_ready}, 2'b10); end
    rst = 1'b0;
    sel = 1'b1;
    model_reset(1, 1'b1);
    // single-weight sweeps, second one back-to-back
    run_phase(NW_PT, 6, 32'h0, 32'h5, 32'h0, 32'h0, 16'h0);
    sel = 1'b0;
  endtask

  initial begin
    test_reset();
    test_load();
    test_sweep();
    test_hold();
    test_conflicts();
    test_back_to_back();
    test_reset_mid_sweep();
    test_pretrained();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
